// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register with valid/ready flow control,
// a two-entry skid buffer, synchronous flush and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 101,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_count
);

  // Encoding chosen so bit 0 is the main valid flag and bit 1 the skid valid flag,
  // letting out_valid and in_ready come straight from state register bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] BUBBLE_MAX = '1;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    bubble_q, bubble_d;

  logic accept;
  logic drain;

  assign accept = in_valid && !state_q[1];
  assign drain  = state_q[0] && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      bubble_q    <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      bubble_q    <= bubble_d;
    end
  end

  // Ctrl is zeroed whenever its entry goes invalid, so a bubble never carries live control.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = ST_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (drain) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (!state_q[0] && (bubble_q != BUBBLE_MAX)) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  assign in_ready     = ~state_q[1];
  assign out_valid    = state_q[0];
  assign out_ctrl     = main_ctrl_q;
  assign out_data     = main_data_q;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized
// traffic compared against a FIFO-queue reference model.
module tb_pipe_stage_reg;
  localparam int CW = 6;
  localparam int DW = 101;
  localparam int NW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] bubble_count;
  logic          in_ready3, out_valid3;
  logic [CW-1:0] out_ctrl3;
  logic [DW-1:0] out_data3;
  logic [2:0]    bubble_count3;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .bubble_count(bubble_count)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_ctrl(out_ctrl3), .out_data(out_data3),
    .bubble_count(bubble_count3)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  // Reference model: the stage is a FIFO of at most two beats.
  beat_t mq[$];
  int    m_bub  = 0;
  int    m_bub3 = 0;
  int    n_cmp  = 0;
  int    n_fail = 0;

  function automatic logic [DW-1:0] rand_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic step();
    bit acc, drn;
    @(posedge clk);
    acc = in_valid && (mq.size() < 2);
    drn = out_ready && (mq.size() > 0);
    if (reset) begin
      mq.delete();
      m_bub  = 0;
      m_bub3 = 0;
    end else begin
      if (mq.size() == 0) begin
        if (m_bub < 65535) m_bub++;
        if (m_bub3 < 7) m_bub3++;
      end
      if (flush) mq.delete();
      else begin
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back('{c: in_ctrl, d: in_data});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); reset = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_init_ready: got %0b want 1", in_ready); end
    n_cmp++; if (bubble_count !== '0) begin n_fail++; $display("[TB] FAIL rst_init_bubble: got %0d want 0", bubble_count); end
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 6'h2A; in_data = rand_data(); step();
    in_data = rand_data(); step();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_fill_full: ready=%0b valid=%0b want 0/1", in_ready, out_valid); end
    reset = 1'b1; step(); reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_ctrl !== '0) begin n_fail++; $display("[TB] FAIL rst_out_ctrl: got %h want 0", out_ctrl); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("[TB] FAIL rst_out_data: got %h want 0", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (bubble_count !== '0) begin n_fail++; $display("[TB] FAIL rst_bubble: got %0d want 0", bubble_count); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_ctrl = CW'($urandom); in_data = DW'(k);
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== DW'(k)) begin n_fail++; $display("[TB] FAIL stream_beat%0d: valid=%0b data=%0h want 1/%0h", k, out_valid, out_data, k); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_ready%0d: got %0b want 1", k, in_ready); end
    end
    in_valid = 1'b0; step();
    n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin n_fail++; $display("[TB] FAIL stream_end: valid=%0b ctrl=%h want 0/0", out_valid, out_ctrl); end
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] a, b, c;
    a = rand_data(); b = rand_data(); c = rand_data();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 6'h01; in_data = a; step();
    out_ready = 1'b0; in_ctrl = 6'h02; in_data = b; step();
    n_cmp++; if (out_data !== a || in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_full: data=%h ready=%0b want %h/0", out_data, in_ready, a); end
    in_ctrl = 6'h04; in_data = c; step();
    n_cmp++; if (out_data !== a || out_ctrl !== 6'h01 || in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hold: data=%h ctrl=%h ready=%0b want %h/01/0", out_data, out_ctrl, in_ready, a); end
    out_ready = 1'b1; step();
    n_cmp++; if (out_data !== b || out_ctrl !== 6'h02 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_second: data=%h ctrl=%h ready=%0b want %h/02/1", out_data, out_ctrl, in_ready, b); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== c || out_ctrl !== 6'h04 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_third: data=%h ctrl=%h valid=%0b want %h/04/1", out_data, out_ctrl, out_valid, c); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drained: valid=%0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 6'h3F; in_data = rand_data(); step();
    in_data = rand_data(); step();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_prefull: ready=%0b want 0", in_ready); end
    flush = 1'b1; in_ctrl = 6'b010001; in_data = rand_data(); step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_full: valid=%0b ctrl=%h ready=%0b want 0/0/1", out_valid, out_ctrl, in_ready); end
    // Flush from ONE, where the incoming beat would otherwise be accepted.
    in_valid = 1'b1; in_ctrl = 6'h15; in_data = rand_data(); step();
    flush = 1'b1; in_ctrl = 6'b010001; in_data = rand_data(); step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin n_fail++; $display("[TB] FAIL flush_one_c%0d: valid=%0b ctrl=%h want 0/0", i, out_valid, out_ctrl); end
      step();
    end
  endtask

  task automatic test_bubble_counter();
    reset = 1'b1; step(); reset = 1'b0; in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_cmp++; if (bubble_count3 !== 3'((i > 7) ? 7 : i)) begin n_fail++; $display("[TB] FAIL bubble3_c%0d: got %0d want %0d", i, bubble_count3, (i > 7) ? 7 : i); end
      n_cmp++; if (bubble_count !== NW'(i)) begin n_fail++; $display("[TB] FAIL bubble16_c%0d: got %0d want %0d", i, bubble_count, i); end
    end
  endtask

  task automatic test_random();
    beat_t         f;
    logic [CW-1:0] exp_ctrl;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      reset     = ($urandom_range(0, 999) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_ctrl   = CW'($urandom);
      in_data   = rand_data();
      step();
      f = (mq.size() > 0) ? mq[0] : '0;
      exp_ctrl = (mq.size() > 0) ? f.c : '0;
      n_cmp++; if (out_valid !== (mq.size() > 0) || out_valid3 !== (mq.size() > 0)) begin n_fail++; $display("[TB] FAIL rnd_valid c%0d: got %0b/%0b want %0b", cyc, out_valid, out_valid3, mq.size() > 0); end
      n_cmp++; if (in_ready !== (mq.size() < 2) || in_ready3 !== (mq.size() < 2)) begin n_fail++; $display("[TB] FAIL rnd_ready c%0d: got %0b/%0b want %0b", cyc, in_ready, in_ready3, mq.size() < 2); end
      n_cmp++; if (out_ctrl !== exp_ctrl || out_ctrl3 !== exp_ctrl) begin n_fail++; $display("[TB] FAIL rnd_ctrl c%0d: got %h/%h want %h", cyc, out_ctrl, out_ctrl3, exp_ctrl); end
      if (mq.size() > 0) begin
        n_cmp++; if (out_data !== f.d || out_data3 !== f.d) begin n_fail++; $display("[TB] FAIL rnd_data c%0d: got %h/%h want %h", cyc, out_data, out_data3, f.d); end
      end
      n_cmp++; if (bubble_count !== NW'(m_bub) || bubble_count3 !== 3'(m_bub3)) begin n_fail++; $display("[TB] FAIL rnd_bubble c%0d: got %0d/%0d want %0d/%0d", cyc, bubble_count, bubble_count3, m_bub, m_bub3); end
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_bubble_counter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the pipelined processor, replacing the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a control bundle and a data bundle between stages and adds valid/ready flow control, a two-entry skid buffer for full throughput under back-pressure, and a synchronous flush. Flushing inserts a bubble with zeroed control bits. A saturating counter reports bubble cycles for performance analysis.

## Interface
- CTRL_W, 6, control bundle width (MemRead, MemWrite, Branch, MemtoReg, RegWrite, zero for EX/MEM); must be ≥1
- DATA_W, 101, data bundle width (EA, ALURes, readData2, writeReg for EX/MEM); must be ≥1
- CNT_W, 16, width of bubble counter; must be ≥1
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all held and incoming beats this cycle
- in_valid  in  1  upstream beat present
- in_ready  out  1  block can accept a beat; registered, equals !skid_valid
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  out_ctrl/out_data hold a valid beat
- out_ready  in  1  downstream accepts beat
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0
- out_data  out  DATA_W  data bundle
- bubble_count  out  CNT_W  saturating count of cycles with out_valid=0

## Operation
- Storage: main entry (drives out_*) and skid entry, each holding valid, ctrl, and data. All outputs come directly from registers, with no combinational in→out path.
- Handshakes: accept = in_valid && in_ready; drain = out_valid && out_ready.
- States (by valid bits):
  - EMPTY: main=0, skid=0
  - ONE: main=1, skid=0
  - FULL: main=1, skid=1
- EMPTY:
  - accept → ONE, beat loaded into main
- ONE:
  - accept and drain → ONE, new beat into main
  - accept and no drain → FULL, new beat into skid
  - drain and no accept → EMPTY
  - neither → hold
- FULL (in_ready=0, so no accept):
  - drain → ONE, skid moves into main
  - no drain → hold
- Ordering: strict FIFO. A beat is never duplicated or dropped except by flush.
- Flush (priority over every handshake):
  - Next state is EMPTY.
  - Both valid bits are cleared and both ctrl fields are zeroed.
  - Data fields are held and not cleared.
  - A beat presented on in_* in the flush cycle is discarded, even if in_ready=1.
  - A drain in the flush cycle still completes downstream, because out_* was valid during that cycle.
- Ctrl gating: ctrl is written as zero whenever the corresponding valid is written 0. Consequently out_ctrl is 0 whenever out_valid=0, and a bubble can never assert MemWrite or RegWrite.
- bubble_count:
  - Increments by 1 on each rising edge where out_valid=0 (pre-edge value).
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.

## Timing
- Reset (synchronous, takes priority over flush): out_valid=0, out_ctrl=0, out_data=0, skid entry zeroed, in_ready=1, bubble_count=0, state EMPTY.
- Latency: a beat accepted at edge N appears on out_* after edge N (1 cycle) when main is empty or draining in the same cycle.
- Throughput: 1 beat/cycle while out_ready=1.
- Back-pressure:
  - With out_ready=0 in ONE, one more beat is accepted into skid.
  - in_ready drops the cycle after the FULL transition.
  - in_ready rises the cycle after the first drain from FULL.
- Reset or flush mid-FULL: both beats are lost and in_ready=1 on the next cycle.
- Widths: no arithmetic on data. bubble_count is an unsigned CNT_W-bit value that does not wrap.

## Test plan
- Reset with data in flight: hold reset for 1 cycle while FULL → next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1, bubble_count=0.
- Streaming: out_ready=1, send 8 beats with data 0..7 back-to-back → out_data 0..7 on consecutive cycles, each 1 cycle after its accept, in_ready held at 1.
- Back-pressure: stream beats A, B, C with out_ready=0 from the cycle after A is accepted → A held on out_*, B held in skid, in_ready=0, C not accepted. Then raise out_ready → A, B, C emerge in order with no loss.
- Flush: in FULL with ctrl=6'b111111, assert flush together with in_valid=1 and ctrl=6'b010001 → next cycle out_valid=0, out_ctrl=0, in_ready=1, and the flushed-cycle beat never appears.
- Bubble counter with CNT_W=3: leave the block idle for 10 cycles after reset → bubble_count reads 1..7 and then stays at 7.
- Randomised valid/ready/flush over 10k cycles against a queue model → output order and content match the model, and out_ctrl=0 whenever out_valid=0.
